// File: rtl/arbitro_wrr.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_wrr
// Brief    : Weighted round-robin pop/push scheduler for a 4-in/4-out FIFO switch.
//            Optional macro ARB_STALL_GLOBAL_EN: any almost_full stalls all pops
//            and holds the current turn with its credit intact.
// Revision : 1.0
// ============================================================================
module arbitro_wrr #(
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] fifo_empty,
  input  logic [3:0] almost_full,
  input  logic [7:0] dest_head,
  output logic [3:0] pop,
  output logic [3:0] push,
  output logic [1:0] dest_out,
  output logic [1:0] active
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [3:0] C_W0 = 4'(W0);
  localparam logic [3:0] C_W1 = 4'(W1);
  localparam logic [3:0] C_W2 = 4'(W2);
  localparam logic [3:0] C_W3 = 4'(W3);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_active;
  logic [1:0] w_active_nxt;
  logic [3:0] r_credit;
  logic [3:0] w_credit_nxt;
  logic [1:0] r_pop_dest;
  logic [1:0] w_head_dest;
  logic       w_elig;
  logic       w_hold;
  logic       w_fire;
  logic       w_idle_found;
  logic [1:0] w_idle_idx;
  logic       w_turn_found;
  logic [1:0] w_turn_idx;

  function automatic logic [3:0] f_weight(input logic [1:0] idx);
    case (idx)
      2'd0:    f_weight = C_W0;
      2'd1:    f_weight = C_W1;
      2'd2:    f_weight = C_W2;
      default: f_weight = C_W3;
    endcase
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    f_onehot = 4'b0001 << idx;
  endfunction

  always_comb begin
    case (r_active)
      2'd0:    w_head_dest = dest_head[1:0];
      2'd1:    w_head_dest = dest_head[3:2];
      2'd2:    w_head_dest = dest_head[5:4];
      default: w_head_dest = dest_head[7:6];
    endcase
  end

  // Idle wake-up scans a, a+1, a+2, a+3; lowest offset wins.
  always_comb begin
    w_idle_found = 1'b0;
    w_idle_idx   = r_active;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[r_active + 2'(k)]) begin
        w_idle_found = 1'b1;
        w_idle_idx   = r_active + 2'(k);
      end
    end
  end

  // End-of-turn scans a+1, a+2, a+3 and finally a itself (offset 4 wraps to 0).
  always_comb begin
    w_turn_found = 1'b0;
    w_turn_idx   = r_active;
    for (int k = 4; k >= 1; k--) begin
      if (!fifo_empty[r_active + 2'(k)]) begin
        w_turn_found = 1'b1;
        w_turn_idx   = r_active + 2'(k);
      end
    end
  end

`ifdef ARB_STALL_GLOBAL_EN
  assign w_hold = |almost_full;
  assign w_elig = !fifo_empty[r_active];
`else
  assign w_hold = 1'b0;
  assign w_elig = !fifo_empty[r_active] && !almost_full[w_head_dest];
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_credit_nxt = r_credit;
    w_fire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_found) begin
          w_state_nxt  = ST_SERVE;
          w_active_nxt = w_idle_idx;
          w_credit_nxt = f_weight(w_idle_idx);
        end
      end
      ST_SERVE: begin
        if (!w_hold) begin
          w_fire = w_elig;
          // An ineligible source forfeits whatever credit it still had.
          if (!w_elig || (r_credit == 4'd1)) begin
            if (w_turn_found) begin
              w_active_nxt = w_turn_idx;
              w_credit_nxt = f_weight(w_turn_idx);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_credit_nxt = r_credit - 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= ST_IDLE;
      r_active <= 2'd0;
      r_credit <= C_W0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  // Pop stage captures the head dest so the push one cycle later routes it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop        <= 4'b0000;
      push       <= 4'b0000;
      dest_out   <= 2'd0;
      r_pop_dest <= 2'd0;
    end else begin
      pop  <= w_fire ? f_onehot(r_active) : 4'b0000;
      push <= (|pop) ? f_onehot(r_pop_dest) : 4'b0000;
      if (w_fire) begin
        r_pop_dest <= w_head_dest;
      end
      if (|pop) begin
        dest_out <= r_pop_dest;
      end
    end
  end

  assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_wrr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_wrr
// Brief    : Self-checking bench for arbitro_wrr with a behavioural WRR model.
// Revision : 1.0
// ============================================================================
module tb_arbitro_wrr;

  logic       clk;
  logic       reset_L;
  logic [3:0] fifo_empty;
  logic [3:0] almost_full;
  logic [7:0] dest_head;
  logic [3:0] pop;
  logic [3:0] push;
  logic [1:0] dest_out;
  logic [1:0] active;

  int checks;
  int failures;

  bit         m_serving;
  int         m_active;
  int         m_credit;
  logic [3:0] m_pop;
  logic [3:0] m_push;
  logic [1:0] m_pdest;
  logic [1:0] m_dout;

  arbitro_wrr dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .fifo_empty (fifo_empty),
    .almost_full(almost_full),
    .dest_head  (dest_head),
    .pop        (pop),
    .push       (push),
    .dest_out   (dest_out),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int wt(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Pop order for all four sources busy and nothing almost full.
  function automatic logic [3:0] wrr_pat(input int n);
    int r;
    r = n % 10;
    if (r < 4) return 4'b0001;
    if (r < 7) return 4'b0010;
    if (r < 9) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic model_reset();
    m_serving = 1'b0;
    m_active  = 0;
    m_credit  = 4;
    m_pop     = 4'b0000;
    m_push    = 4'b0000;
    m_pdest   = 2'd0;
    m_dout    = 2'd0;
  endtask

  task automatic model_clock();
    int a;
    int s;
    logic [1:0] d;
    bit can;
    bit stalled;
    bit found;
    logic [3:0] nxt_pop;
    m_push = (m_pop != 4'b0000) ? (4'b0001 << m_pdest) : 4'b0000;
    if (m_pop != 4'b0000) m_dout = m_pdest;
    nxt_pop = 4'b0000;
    if (!m_serving) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        s = (m_active + k) % 4;
        if (!found && !fifo_empty[s]) begin
          found     = 1'b1;
          m_serving = 1'b1;
          m_active  = s;
          m_credit  = wt(s);
        end
      end
    end else begin
      a = m_active;
      d = dest_head[2*a +: 2];
`ifdef ARB_STALL_GLOBAL_EN
      stalled = |almost_full;
      can     = !fifo_empty[a];
`else
      stalled = 1'b0;
      can     = !fifo_empty[a] && !almost_full[d];
`endif
      if (!stalled) begin
        if (can) begin
          nxt_pop  = 4'b0001 << a;
          m_pdest  = d;
          m_credit = m_credit - 1;
        end
        if (!can || m_credit == 0) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            s = (a + k) % 4;
            if (!found && !fifo_empty[s]) begin
              found    = 1'b1;
              m_active = s;
              m_credit = wt(s);
            end
          end
          if (!found) m_serving = 1'b0;
        end
      end
    end
    m_pop = nxt_pop;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L     = 1'b0;
    fifo_empty  = 4'hF;
    almost_full = 4'h0;
    dest_head   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop); end
    checks++;
    if (push !== 4'b0000) begin failures++; $display("FAIL reset_push got=%b exp=0000", push); end
    checks++;
    if (dest_out !== 2'd0) begin failures++; $display("FAIL reset_dest_out got=%0d exp=0", dest_out); end
    checks++;
    if (active !== 2'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active); end
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_weights();
    fifo_empty  = 4'h0;
    almost_full = 4'h0;
    dest_head   = 8'b11_10_01_00;
    apply_reset();
    for (int cyc = 0; cyc <= 40; cyc++) begin
      step();
      if (cyc >= 1) begin
        checks++;
        if (pop !== wrr_pat(cyc - 1)) begin
          failures++;
          $display("FAIL weights_pop cyc=%0d got=%b exp=%b", cyc, pop, wrr_pat(cyc - 1));
        end
      end
      checks++;
      if (push !== m_push) begin
        failures++;
        $display("FAIL weights_push cyc=%0d got=%b exp=%b", cyc, push, m_push);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] first;
    int p0cnt;
    fifo_empty  = 4'h0;
    almost_full = 4'h0;
    dest_head   = 8'b11_10_01_00;
    apply_reset();
    for (int cyc = 0; cyc < 7; cyc++) step();
    checks++;
    if (pop !== 4'b0010) begin failures++; $display("FAIL midreset_p1turn got=%b exp=0010", pop); end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL midreset_pop got=%b exp=0000", pop); end
    checks++;
    if (push !== 4'b0000) begin failures++; $display("FAIL midreset_push got=%b exp=0000", push); end
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    first = 4'b0000;
    p0cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (first == 4'b0000) first = pop;
      if (pop == 4'b0001) p0cnt++;
      checks++;
      if (pop !== m_pop) begin
        failures++;
        $display("FAIL midreset_model_pop cyc=%0d got=%b exp=%b", cyc, pop, m_pop);
      end
    end
    checks++;
    if (first !== 4'b0001) begin failures++; $display("FAIL midreset_first got=%b exp=0001", first); end
    checks++;
    if (p0cnt != 4) begin failures++; $display("FAIL midreset_p0count got=%0d exp=4", p0cnt); end
  endtask

  task automatic test_single_source();
    fifo_empty  = 4'b1011;
    almost_full = 4'h0;
    dest_head   = 8'b00_11_00_00;
    apply_reset();
    for (int cyc = 0; cyc < 14; cyc++) begin
      step();
      checks++;
      if (active !== 2'd2) begin failures++; $display("FAIL single_active cyc=%0d got=%0d exp=2", cyc, active); end
      if (cyc >= 1) begin
        checks++;
        if (pop !== 4'b0100) begin failures++; $display("FAIL single_pop cyc=%0d got=%b exp=0100", cyc, pop); end
      end
      if (cyc >= 2) begin
        checks++;
        if (push !== 4'b1000 || dest_out !== 2'd3) begin
          failures++;
          $display("FAIL single_push cyc=%0d got=%b/%0d exp=1000/3", cyc, push, dest_out);
        end
      end
    end
  endtask

  task automatic test_af_skip();
    bit p0_seen;
    fifo_empty  = 4'h0;
    almost_full = 4'b0010;
    dest_head   = 8'b11_10_00_01;
    apply_reset();
    step();
    checks++;
    if (active !== 2'd0) begin failures++; $display("FAIL afskip_start got=%0d exp=0", active); end
    step();
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL afskip_nopop got=%b exp=0000", pop); end
`ifdef ARB_STALL_GLOBAL_EN
    checks++;
    if (active !== 2'd0) begin failures++; $display("FAIL afskip_hold got=%0d exp=0", active); end
    step();
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL afskip_stall got=%b exp=0000", pop); end
`else
    checks++;
    if (active !== 2'd1) begin failures++; $display("FAIL afskip_adv got=%0d exp=1", active); end
    step();
    checks++;
    if (pop !== 4'b0010) begin failures++; $display("FAIL afskip_p1 got=%b exp=0010", pop); end
`endif
    p0_seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (pop[0]) p0_seen = 1'b1;
      checks++;
      if (pop !== m_pop) begin
        failures++;
        $display("FAIL afskip_model_pop cyc=%0d got=%b exp=%b", cyc, pop, m_pop);
      end
    end
    checks++;
    if (p0_seen) begin failures++; $display("FAIL afskip_p0_popped got=1 exp=0"); end
    almost_full = 4'h0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      checks++;
      if (pop !== m_pop || push !== m_push) begin
        failures++;
        $display("FAIL afskip_release cyc=%0d got=%b/%b exp=%b/%b", cyc, pop, push, m_pop, m_push);
      end
    end
  endtask

  task automatic test_early_empty();
    bit got;
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    fifo_empty  = 4'h0;
    almost_full = 4'h0;
    dest_head   = 8'b11_10_01_00;
    apply_reset();
    got = 1'b0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      step();
      if (pop == 4'b0010) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL early_wait_p1 got=timeout exp=pop0010");
    end else begin
      fifo_empty[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        checks++;
        if (pop !== exp_seq[i] || pop !== m_pop) begin
          failures++;
          $display("FAIL early_seq i=%0d got=%b exp=%b", i, pop, exp_seq[i]);
        end
        if (i == 0) begin
          checks++;
          if (active !== 2'd2) begin failures++; $display("FAIL early_active got=%0d exp=2", active); end
        end
      end
    end
  endtask

  task automatic test_idle_wake();
    fifo_empty  = 4'hF;
    almost_full = 4'h0;
    dest_head   = 8'b01_00_00_00;
    apply_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      checks++;
      if (pop !== 4'b0000 || push !== 4'b0000) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got=%b/%b exp=0000/0000", cyc, pop, push);
      end
    end
    fifo_empty = 4'b0111;
    step();
    step();
    checks++;
    if (pop !== 4'b1000) begin failures++; $display("FAIL idle_wake_pop got=%b exp=1000", pop); end
    step();
    checks++;
    if (push !== 4'b0010 || dest_out !== 2'd1) begin
      failures++;
      $display("FAIL idle_wake_push got=%b/%0d exp=0010/1", push, dest_out);
    end
  endtask

  task automatic test_random();
    fifo_empty  = 4'h0;
    almost_full = 4'h0;
    dest_head   = 8'($urandom);
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 2) == 0) fifo_empty = 4'($urandom);
      if ($urandom_range(0, 3) == 0) almost_full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 1) == 0) dest_head = 8'($urandom);
      step();
      checks++;
      if (pop !== m_pop) begin
        failures++;
        $display("FAIL rand_pop cyc=%0d got=%b exp=%b", cyc, pop, m_pop);
      end
      checks++;
      if (push !== m_push) begin
        failures++;
        $display("FAIL rand_push cyc=%0d got=%b exp=%b", cyc, push, m_push);
      end
      checks++;
      if (active !== 2'(m_active)) begin
        failures++;
        $display("FAIL rand_active cyc=%0d got=%0d exp=%0d", cyc, active, m_active);
      end
      if (m_push != 4'b0000) begin
        checks++;
        if (dest_out !== m_dout) begin
          failures++;
          $display("FAIL rand_dest_out cyc=%0d got=%0d exp=%0d", cyc, dest_out, m_dout);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_weights();
    test_reset_midstream();
    test_single_source();
    test_af_skip();
    test_early_empty();
    test_idle_wake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
